// File: rtl/shape_processor_apb_bridge.sv
// APB slave front-end for shape_processor: posts CTRL writes into an in-order buffer
// and turns CTRL reads into a single read strobe once every earlier write has drained.
module shape_processor_apb_bridge #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CTRL_ADDR  = 0,
  parameter int unsigned WBUF_DEPTH = 4,
  localparam int unsigned LVL_W     = $clog2(WBUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic                  pready,
  output logic [31:0]           prdata,
  output logic                  pslverr,
  input  logic                  busy,
  output logic                  write,
  output logic [31:0]           write_data,
  output logic                  read,
  input  logic [31:0]           read_data,
  output logic [LVL_W-1:0]      wbuf_level
);

  localparam int unsigned PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_ISSUE, RD_RESP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        mem [WBUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               access, ctrl_hit, not_full, push, pop;

  assign access     = psel && penable;
  assign ctrl_hit   = (paddr == ADDR_WIDTH'(CTRL_ADDR));
  assign not_full   = (level < LVL_W'(WBUF_DEPTH));
  assign wbuf_level = level;

  // Pointer wrap handles non-power-of-2 depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pready  = 1'b0;
    pslverr = 1'b0;
    push    = 1'b0;
    read    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (!ctrl_hit) begin
            pready  = 1'b1;
            pslverr = 1'b1;
          end else if (pwrite) begin
            pready = not_full;
            push   = not_full;
          end else begin
            state_d = (level == '0) ? RD_ISSUE : RD_WAIT;
          end
        end
      end
      RD_WAIT:  if (level == '0) state_d = RD_ISSUE;
      RD_ISSUE: begin
        read    = 1'b1;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        pready  = 1'b1;
        state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
    // Keep the APB side quiet while reset is held, even with an access on the bus.
    if (rst) begin
      pready  = 1'b0;
      pslverr = 1'b0;
      push    = 1'b0;
    end
  end

  // The read strobe owns its cycle; drain resumes afterwards.
  assign write      = (level != '0) && !busy && (state_q != RD_ISSUE) && !rst;
  assign pop        = write;
  assign write_data = (level != '0) ? mem[rd_ptr] : 32'd0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pwdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        prdata <= '0;
    else if (state_q == RD_ISSUE)   prdata <= read_data;
  end

endmodule

// File: tb/tb_shape_processor_apb_bridge.sv
// Directed bench for shape_processor_apb_bridge with a write-data scoreboard and
// strobe monitor checking ordering and read/write exclusivity.
module tb_shape_processor_apb_bridge;

  localparam int unsigned LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             psel, penable, pwrite;
  logic [7:0]       paddr;
  logic [31:0]      pwdata;
  logic             pready, pslverr;
  logic [31:0]      prdata;
  logic             busy;
  logic             write, read;
  logic [31:0]      write_data, read_data;
  logic [LVL_W-1:0] wbuf_level;

  int          checks = 0;
  int          failures = 0;
  int          n_writes = 0;
  int          n_reads = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          read_cyc = 0;
  int          write_cycles[$];
  logic [31:0] exp_q[$];

  shape_processor_apb_bridge dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .busy(busy), .write(write), .write_data(write_data),
    .read(read), .read_data(read_data), .wbuf_level(wbuf_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (write) begin
        logic [31:0] e;
        n_writes++;
        write_cycles.push_back(cyc);
        check("write_sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_data", write_data, e);
        end
      end
      if (read) begin
        n_reads++;
        read_cyc = cyc;
        check("read_level_zero", 32'(wbuf_level), 32'd0);
        check("read_write_excl", 32'(write), 32'd0);
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                          output int acc, output logic err, output logic [31:0] rdata);
    bit done = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    acc = 0; err = 1'b0; rdata = '0;
    while (!done && acc < 50) begin
      @(negedge clk);
      acc++;
      if (pready) begin
        done = 1;
        err = pslverr;
        rdata = prdata;
        accept_cyc = cyc;
        if (wr && !pslverr) exp_q.push_back(data);
      end
    end
    check("xfer_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    int acc;
    logic err;
    logic [31:0] rd;
    int nw, nr, wc0;

    // 1: reset with an access on the bus
    rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00;
    pwdata = 32'hDEAD; busy = 1'b0; read_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_read", 32'(read), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_level", 32'(wbuf_level), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;

    // 2: single write, strobe one cycle after acceptance
    nw = n_writes;
    apb_xfer(1'b1, 8'h00, 32'h21, acc, err, rd);
    check("w1_acc_cycles", 32'(acc), 32'd1);
    check("w1_pslverr", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    check("w1_strobe_count", 32'(n_writes - nw), 32'd1);
    check("w1_latency", 32'(write_cycles[write_cycles.size()-1] - accept_cyc), 32'd1);

    // 3: fill the buffer while busy, fifth write stalls
    busy = 1'b1;
    nw = n_writes;
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b1, 8'h00, 32'h11 + 32'(i), acc, err, rd);
      check("fill_acc_cycles", 32'(acc), 32'd1);
    end
    @(negedge clk);
    check("fill_level", 32'(wbuf_level), 32'd4);
    wc0 = write_cycles.size();
    fork
      apb_xfer(1'b1, 8'h00, 32'h15, acc, err, rd);
      begin repeat (4) @(posedge clk); #1; busy = 1'b0; end
    join
    check("full_stall_cycles", 32'(acc), 32'd4);
    repeat (8) @(negedge clk);
    check("full_strobe_count", 32'(n_writes - nw), 32'd5);
    check("full_level_empty", 32'(wbuf_level), 32'd0);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);
    check("full_back_to_back", 32'(write_cycles[write_cycles.size()-1] - write_cycles[wc0]), 32'd4);

    // 4: read waits for posted writes to drain
    busy = 1'b1; read_data = 32'h22;
    nw = n_writes; nr = n_reads;
    apb_xfer(1'b1, 8'h00, 32'h11, acc, err, rd);
    apb_xfer(1'b1, 8'h00, 32'h22, acc, err, rd);
    fork
      apb_xfer(1'b0, 8'h00, 32'h0, acc, err, rd);
      begin repeat (4) @(posedge clk); #1; busy = 1'b0; end
    join
    check("rd_acc_cycles", 32'(acc), 32'd7);
    check("rd_prdata", rd, 32'h22);
    check("rd_pslverr", 32'(err), 32'd0);
    check("rd_strobe_count", 32'(n_reads - nr), 32'd1);
    check("rd_write_count", 32'(n_writes - nw), 32'd2);
    check("rd_after_writes", 32'(read_cyc > write_cycles[write_cycles.size()-1]), 32'd1);

    // 5: decode errors
    nw = n_writes; nr = n_reads;
    apb_xfer(1'b1, 8'h04, 32'h99, acc, err, rd);
    check("derr_w_cycles", 32'(acc), 32'd1);
    check("derr_w_pslverr", 32'(err), 32'd1);
    apb_xfer(1'b0, 8'h04, 32'h0, acc, err, rd);
    check("derr_r_cycles", 32'(acc), 32'd1);
    check("derr_r_pslverr", 32'(err), 32'd1);
    repeat (4) @(negedge clk);
    check("derr_level", 32'(wbuf_level), 32'd0);
    check("derr_prdata", prdata, 32'h22);
    check("derr_no_write", 32'(n_writes - nw), 32'd0);
    check("derr_no_read", 32'(n_reads - nr), 32'd0);

    // 6: reset while a read is stuck behind buffered writes
    busy = 1'b1;
    apb_xfer(1'b1, 8'h00, 32'h33, acc, err, rd);
    apb_xfer(1'b1, 8'h00, 32'h44, acc, err, rd);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b0; paddr = 8'h00;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_level_before", 32'(wbuf_level), 32'd2);
    check("midrst_pready_before", 32'(pready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    nw = n_writes; nr = n_reads;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; busy = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_level_after", 32'(wbuf_level), 32'd0);
    check("midrst_no_write", 32'(n_writes - nw), 32'd0);
    check("midrst_no_read", 32'(n_reads - nr), 32'd0);
    read_data = 32'h5A;
    apb_xfer(1'b0, 8'h00, 32'h0, acc, err, rd);
    check("midrst_rd_cycles", 32'(acc), 32'd3);
    check("midrst_rd_prdata", rd, 32'h5A);
    check("midrst_rd_pslverr", 32'(err), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
